dmem_arbiter: RTL and testbench

Single-port data-memory arbiter that shares the SOPC `DataMemory` between the CPU load/store path and a loader/debug master, which preloads or inspects data over a request/grant handshake. It sits between `CPU`, the loader and `DM`, and drives the memory address, write and length lines. CPU traffic has priority, with bounded starvation for the loader. The loader can lock the memory for a bounded burst.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arb_stats.sv | 44 ++++
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its statistics block.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK  = 2'd1,
        ST_YIELD = 2'd2
    } arb_state_e;

    // Access length codes understood by DataMemory.
    localparam logic [2:0] LEN_BYTE = 3'd0;
    localparam logic [2:0] LEN_HALF = 3'd1;
    localparam logic [2:0] LEN_WORD = 3'd2;

    localparam int unsigned DEF_STARVE_LIMIT = 4;
    localparam int unsigned DEF_BURST_MAX    = 16;
    localparam int unsigned DEF_CNT_W        = 16;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU/loader masters, the arbiter and DataMemory.
interface dmem_arbiter_if;
    logic        cpu_req;
    logic        cpu_wr;
    logic [2:0]  cpu_len;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;

    logic        ldr_req;
    logic        ldr_wr;
    logic        ldr_lock;
    logic [2:0]  ldr_len;
    logic [31:0] ldr_addr;
    logic [31:0] ldr_wdata;
    logic        ldr_gnt;
    logic [31:0] ldr_rdata;

    logic        mem_wr;
    logic [2:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_wr, cpu_len, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_wr, ldr_lock, ldr_len, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_stall, cpu_rdata,
        output ldr_gnt, ldr_rdata,
        output mem_wr, mem_len, mem_addr, mem_wdata
    );

    // Environment side: requesters plus the memory itself.
    modport master (
        output cpu_req, cpu_wr, cpu_len, cpu_addr, cpu_wdata,
        output ldr_req, ldr_wr, ldr_lock, ldr_len, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_stall, cpu_rdata,
        input  ldr_gnt, ldr_rdata,
        input  mem_wr, mem_len, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arb_stats.sv
// Saturating grant/conflict counters for the data-memory arbiter.
module dmem_arb_stats #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             rstn,
    input  logic             i_cpu_gnt,
    input  logic             i_ldr_gnt,
    input  logic             i_conflict,
    output logic [CNT_W-1:0] stat_cpu_gnt,
    output logic [CNT_W-1:0] stat_ldr_gnt,
    output logic [CNT_W-1:0] stat_conflict
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cpu_gnt;
    logic [CNT_W-1:0] r_ldr_gnt;
    logic [CNT_W-1:0] r_conflict;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != CNT_MAX)) begin
            return v + CNT_W'(1);
        end else begin
            return v;
        end
    endfunction

    // Counter registers, cleared only by reset.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_cpu_gnt  <= {CNT_W{1'b0}};
            r_ldr_gnt  <= {CNT_W{1'b0}};
            r_conflict <= {CNT_W{1'b0}};
        end else begin
            r_cpu_gnt  <= sat_inc(r_cpu_gnt, i_cpu_gnt);
            r_ldr_gnt  <= sat_inc(r_ldr_gnt, i_ldr_gnt);
            r_conflict <= sat_inc(r_conflict, i_conflict);
        end
    end

    assign stat_cpu_gnt  = r_cpu_gnt;
    assign stat_ldr_gnt  = r_ldr_gnt;
    assign stat_conflict = r_conflict;
endmodule

// File: rtl/dmem_arbiter.sv
// CPU-priority arbiter sharing DataMemory with a loader that may lock bounded bursts.
// Statistics counters and ports exist only when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned BURST_MAX    = DEF_BURST_MAX
`ifdef DMEM_ARB_STATS_EN
    ,
    parameter int unsigned CNT_W        = DEF_CNT_W
`endif
) (
    input  logic             clock,
    input  logic             rstn,
    dmem_arbiter_if.slave    bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_cpu_gnt,
    output logic [CNT_W-1:0] stat_ldr_gnt,
    output logic [CNT_W-1:0] stat_conflict
`endif
);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned BURST_W  = $clog2(BURST_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_LIMIT);
    localparam logic [BURST_W-1:0]  BURST_TOP  = BURST_W'(BURST_MAX);

    arb_state_e          r_state;
    arb_state_e          w_next_state;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic [STARVE_W-1:0] w_starve_nxt;
    logic [STARVE_W-1:0] w_arb_starve;
    logic [BURST_W-1:0]  r_burst_cnt;
    logic [BURST_W-1:0]  w_burst_nxt;
    logic [BURST_W-1:0]  w_burst_inc;
    logic                w_arb_cpu_gnt;
    logic                w_arb_ldr_gnt;
    logic                w_cpu_gnt_raw;
    logic                w_ldr_gnt_raw;
    logic                w_cpu_gnt;
    logic                w_ldr_gnt;

    // Plain ARB decision, also reused when the loader releases its lock.
    always_comb begin
        w_arb_ldr_gnt = bus.ldr_req & (~bus.cpu_req | (r_starve_cnt == STARVE_TOP));
        w_arb_cpu_gnt = bus.cpu_req & ~w_arb_ldr_gnt;
        if (!bus.ldr_req || w_arb_ldr_gnt) begin
            w_arb_starve = {STARVE_W{1'b0}};
        end else if (r_starve_cnt == STARVE_TOP) begin
            w_arb_starve = STARVE_TOP;
        end else begin
            w_arb_starve = r_starve_cnt + STARVE_W'(1);
        end
        // Burst length including the current cycle; saturates at the limit.
        if (r_burst_cnt == BURST_TOP) begin
            w_burst_inc = BURST_TOP;
        end else begin
            w_burst_inc = r_burst_cnt + BURST_W'(1);
        end
    end

    // Next-state and grant logic.
    always_comb begin
        w_next_state  = r_state;
        w_starve_nxt  = r_starve_cnt;
        w_burst_nxt   = r_burst_cnt;
        w_cpu_gnt_raw = 1'b0;
        w_ldr_gnt_raw = 1'b0;
        case (r_state)
            ST_ARB: begin
                w_cpu_gnt_raw = w_arb_cpu_gnt;
                w_ldr_gnt_raw = w_arb_ldr_gnt;
                w_starve_nxt  = w_arb_starve;
                if (w_arb_ldr_gnt && bus.ldr_lock) begin
                    w_next_state = ST_LOCK;
                    w_burst_nxt  = BURST_W'(1);
                end else begin
                    w_next_state = ST_ARB;
                    w_burst_nxt  = {BURST_W{1'b0}};
                end
            end
            ST_LOCK: begin
                if (!bus.ldr_lock) begin
                    w_cpu_gnt_raw = w_arb_cpu_gnt;
                    w_ldr_gnt_raw = w_arb_ldr_gnt;
                    w_starve_nxt  = w_arb_starve;
                    w_next_state  = ST_ARB;
                    w_burst_nxt   = {BURST_W{1'b0}};
                end else begin
                    w_ldr_gnt_raw = bus.ldr_req;
                    w_starve_nxt  = {STARVE_W{1'b0}};
                    w_burst_nxt   = w_burst_inc;
                    if ((w_burst_inc == BURST_TOP) && bus.cpu_req) begin
                        w_next_state = ST_YIELD;
                    end else begin
                        w_next_state = ST_LOCK;
                    end
                end
            end
            ST_YIELD: begin
                w_cpu_gnt_raw = bus.cpu_req;
                w_starve_nxt  = STARVE_TOP;
                w_burst_nxt   = {BURST_W{1'b0}};
                w_next_state  = ST_ARB;
            end
            default: begin
                w_starve_nxt = {STARVE_W{1'b0}};
                w_burst_nxt  = {BURST_W{1'b0}};
                w_next_state = ST_ARB;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_ARB;
            r_starve_cnt <= {STARVE_W{1'b0}};
            r_burst_cnt  <= {BURST_W{1'b0}};
        end else begin
            r_state      <= w_next_state;
            r_starve_cnt <= w_starve_nxt;
            r_burst_cnt  <= w_burst_nxt;
        end
    end

    // Grants are forced low while reset is asserted, independent of the clock.
    assign w_cpu_gnt = w_cpu_gnt_raw & rstn;
    assign w_ldr_gnt = w_ldr_gnt_raw & rstn;

    assign bus.cpu_gnt   = w_cpu_gnt;
    assign bus.ldr_gnt   = w_ldr_gnt;
    assign bus.cpu_stall = bus.cpu_req & ~w_cpu_gnt;
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.ldr_rdata = bus.mem_rdata;
    assign bus.mem_wr    = (w_cpu_gnt & bus.cpu_wr) | (w_ldr_gnt & bus.ldr_wr);
    assign bus.mem_addr  = w_ldr_gnt ? bus.ldr_addr  : bus.cpu_addr;
    assign bus.mem_wdata = w_ldr_gnt ? bus.ldr_wdata : bus.cpu_wdata;
    assign bus.mem_len   = w_ldr_gnt ? bus.ldr_len   : bus.cpu_len;

`ifdef DMEM_ARB_STATS_EN
    dmem_arb_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clock         (clock),
        .rstn          (rstn),
        .i_cpu_gnt     (w_cpu_gnt),
        .i_ldr_gnt     (w_ldr_gnt),
        .i_conflict    (bus.cpu_req & bus.ldr_req),
        .stat_cpu_gnt  (stat_cpu_gnt),
        .stat_ldr_gnt  (stat_ldr_gnt),
        .stat_conflict (stat_conflict)
    );
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed cycles push expectations, a negedge monitor checks.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam logic [31:0] CPU_WDATA = 32'h1111_2222;
    localparam logic [31:0] LDR_WDATA = 32'hA5A5_A5A5;

    typedef struct {
        string       tag;
        logic        cg;
        logic        lg;
        logic        stall;
        logic        wr;
        logic [2:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic clock;
    logic rstn;
    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];
    logic [31:0] mem [0:63];

    dmem_arbiter_if bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_cpu_gnt;
    logic [15:0] stat_ldr_gnt;
    logic [15:0] stat_conflict;
`endif

    dmem_arbiter dut (
        .clock         (clock),
        .rstn          (rstn),
        .bus           (bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_cpu_gnt  (stat_cpu_gnt),
        .stat_ldr_gnt  (stat_ldr_gnt),
        .stat_conflict (stat_conflict)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memory model: default content is 0x5000_0000 + byte address.
    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h5000_0000 + 32'(i * 4);
        forever begin
            @(posedge clock);
            if (bus.mem_wr === 1'b1) mem[bus.mem_addr[7:2]] = bus.mem_wdata;
        end
    end

    task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", tag, fld, act, exp_v);
        end
    endtask

    // One directed cycle: drive inputs, push hand-computed grants and read data.
    task automatic cyc(input string tag, input logic rn,
                       input logic cr, input logic cw, input logic [31:0] ca,
                       input logic lr, input logic lw, input logic ll, input logic [31:0] la,
                       input logic ecg, input logic elg, input logic [31:0] erd);
        exp_t e;
        rstn          = rn;
        bus.cpu_req   = cr;
        bus.cpu_wr    = cw;
        bus.cpu_addr  = ca;
        bus.ldr_req   = lr;
        bus.ldr_wr    = lw;
        bus.ldr_lock  = ll;
        bus.ldr_addr  = la;
        e.tag   = tag;
        e.cg    = ecg;
        e.lg    = elg;
        e.stall = cr & ~ecg;
        e.wr    = (ecg & cw) | (elg & lw);
        e.len   = elg ? LEN_HALF : LEN_WORD;
        e.addr  = elg ? la : ca;
        e.wdata = elg ? LDR_WDATA : CPU_WDATA;
        e.rdata = erd;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    always @(negedge clock) begin : mon
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, "cpu_gnt",   32'(bus.cpu_gnt),   32'(e.cg));
            chk(e.tag, "ldr_gnt",   32'(bus.ldr_gnt),   32'(e.lg));
            chk(e.tag, "cpu_stall", 32'(bus.cpu_stall), 32'(e.stall));
            chk(e.tag, "mem_wr",    32'(bus.mem_wr),    32'(e.wr));
            chk(e.tag, "mem_len",   32'(bus.mem_len),   32'(e.len));
            chk(e.tag, "mem_addr",  bus.mem_addr,       e.addr);
            chk(e.tag, "mem_wdata", bus.mem_wdata,      e.wdata);
            chk(e.tag, "cpu_rdata", bus.cpu_rdata,      e.rdata);
            chk(e.tag, "ldr_rdata", bus.ldr_rdata,      e.rdata);
        end
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rstn          = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_len   = LEN_WORD;
        bus.cpu_addr  = 32'h0;
        bus.cpu_wdata = CPU_WDATA;
        bus.ldr_req   = 1'b0;
        bus.ldr_wr    = 1'b0;
        bus.ldr_lock  = 1'b0;
        bus.ldr_len   = LEN_HALF;
        bus.ldr_addr  = 32'h0;
        bus.ldr_wdata = LDR_WDATA;
        @(posedge clock);
        #1;

        // Reset: both masters request writes, nothing may be granted.
        cyc("rst", 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 32'h20, 1'b0, 1'b0, 32'h5000_0010);

        // Continuous conflict: CPU x4, loader, CPU x4, loader.
        for (int i = 0; i < 10; i++) begin
            if ((i == 4) || (i == 9))
                cyc("starve", 1'b1, 1'b1, 1'b0, 32'h30, 1'b1, 1'b0, 1'b0, 32'h24, 1'b0, 1'b1, 32'h5000_0024);
            else
                cyc("starve", 1'b1, 1'b1, 1'b0, 32'h30, 1'b1, 1'b0, 1'b0, 32'h24, 1'b1, 1'b0, 32'h5000_0030);
        end
`ifdef DMEM_ARB_STATS_EN
        chk("stats10", "stat_conflict", 32'(stat_conflict), 32'd10);
        chk("stats10", "stat_cpu_gnt",  32'(stat_cpu_gnt),  32'd8);
        chk("stats10", "stat_ldr_gnt",  32'(stat_ldr_gnt),  32'd2);
`endif

        // CPU alone: reads, a store, and read-back of the store.
        cyc("cpu_rd10", 1'b1, 1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h24, 1'b1, 1'b0, 32'h5000_0010);
        cyc("cpu_rd14", 1'b1, 1'b1, 1'b0, 32'h14, 1'b0, 1'b0, 1'b0, 32'h24, 1'b1, 1'b0, 32'h5000_0014);
        cyc("cpu_wr18", 1'b1, 1'b1, 1'b1, 32'h18, 1'b0, 1'b0, 1'b0, 32'h24, 1'b1, 1'b0, 32'h5000_0018);
        cyc("cpu_rd18", 1'b1, 1'b1, 1'b0, 32'h18, 1'b0, 1'b0, 1'b0, 32'h24, 1'b1, 1'b0, CPU_WDATA);
        cyc("ldr_rd20", 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 1'b0, 32'h20, 1'b0, 1'b1, 32'h5000_0020);

        // Locked burst of 16 writes to 0x40..0x7C, CPU waiting from the second beat.
        cyc("lock0", 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 32'h5000_0040);
        for (int k = 1; k < 16; k++) begin
            cyc("burst", 1'b1, 1'b1, 1'b0, 32'h80, 1'b1, 1'b1, 1'b1, 32'h40 + 32'(k * 4),
                1'b0, 1'b1, 32'h5000_0040 + 32'(k * 4));
        end
        cyc("yield",      1'b1, 1'b1, 1'b0, 32'h80, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 32'h5000_0080);
        cyc("post_yield", 1'b1, 1'b1, 1'b0, 32'h80, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 1'b1, LDR_WDATA);
        cyc("cpu_rd7c",   1'b1, 1'b1, 1'b0, 32'h7C, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0, LDR_WDATA);

        // Lock dropped on the fourth beat: CPU wins at once, state is back to ARB.
        cyc("drop0", 1'b1, 1'b0, 1'b0, 32'h84, 1'b1, 1'b1, 1'b1, 32'h90, 1'b0, 1'b1, 32'h5000_0090);
        cyc("drop1", 1'b1, 1'b1, 1'b0, 32'h84, 1'b1, 1'b1, 1'b1, 32'h94, 1'b0, 1'b1, 32'h5000_0094);
        cyc("drop2", 1'b1, 1'b1, 1'b0, 32'h84, 1'b1, 1'b1, 1'b1, 32'h98, 1'b0, 1'b1, 32'h5000_0098);
        cyc("drop3", 1'b1, 1'b1, 1'b0, 32'h84, 1'b1, 1'b1, 1'b0, 32'h9C, 1'b1, 1'b0, 32'h5000_0084);
        cyc("drop4", 1'b1, 1'b1, 1'b0, 32'h88, 1'b1, 1'b1, 1'b1, 32'h9C, 1'b1, 1'b0, 32'h5000_0088);
        cyc("drop5", 1'b1, 1'b0, 1'b0, 32'h88, 1'b1, 1'b1, 1'b0, 32'h9C, 1'b0, 1'b1, 32'h5000_009C);

        // Reset pulse in the middle of a locked burst.
        cyc("rlk0",    1'b1, 1'b0, 1'b0, 32'hA8, 1'b1, 1'b1, 1'b1, 32'hA0, 1'b0, 1'b1, 32'h5000_00A0);
        cyc("rlk1",    1'b1, 1'b0, 1'b0, 32'hA8, 1'b1, 1'b1, 1'b1, 32'hA4, 1'b0, 1'b1, 32'h5000_00A4);
        cyc("rlk_rst", 1'b0, 1'b1, 1'b0, 32'hA8, 1'b1, 1'b1, 1'b1, 32'hA8, 1'b0, 1'b0, 32'h5000_00A8);
        cyc("rlk_rel", 1'b1, 1'b1, 1'b0, 32'hA8, 1'b1, 1'b1, 1'b1, 32'hA8, 1'b1, 1'b0, 32'h5000_00A8);
        cyc("rlk_ldr", 1'b1, 1'b0, 1'b0, 32'hA8, 1'b1, 1'b1, 1'b0, 32'hA8, 1'b0, 1'b1, 32'h5000_00A8);
`ifdef DMEM_ARB_STATS_EN
        chk("stats_rst", "stat_conflict", 32'(stat_conflict), 32'd1);
        chk("stats_rst", "stat_cpu_gnt",  32'(stat_cpu_gnt),  32'd1);
        chk("stats_rst", "stat_ldr_gnt",  32'(stat_ldr_gnt),  32'd1);
`endif

        bus.cpu_req = 1'b0;
        bus.ldr_req = 1'b0;
        @(negedge clock);
        #1;
        chk("scoreboard", "pending", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
